acq_seq_ctrl: RTL and testbench

- Avalon-MM slave that sequences the SS-OCT acquisition datapath.
- Host (Nios) programs a frame count and writes START.
- Block issues one `acq_start` pulse per frame, then waits for the rising edge of the datapath's `acq_done` level.
- Counts completed frames; reports busy/done/timeout status; optionally raises an interrupt.
- Sits beside the acquisition-done status input in the SOPC system and replaces polling of it.

---
 rtl/acq_seq_pkg.sv | 29 ++
 rtl/acq_seq_edge_det.sv | 46 ++++
 rtl/acq_seq_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_acq_seq_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acq_seq_pkg.sv
// Purpose : shared register map, bit indices and FSM state type for the acquisition sequencer.
// Latency : n/a (constants and types only).
// Backpressure: n/a.
package acq_seq_pkg;

    // Avalon register addresses
    localparam logic [1:0] REG_CTRL       = 2'd0;
    localparam logic [1:0] REG_NUM_FRAMES = 2'd1;
    localparam logic [1:0] REG_STATUS     = 2'd2;
    localparam logic [1:0] REG_FRAME_CNT  = 2'd3;

    // CTRL bit positions
    localparam int unsigned CTRL_START  = 0;
    localparam int unsigned CTRL_ABORT  = 1;
    localparam int unsigned CTRL_IRQ_EN = 2;

    // STATUS bit positions
    localparam int unsigned ST_BUSY    = 0;
    localparam int unsigned ST_DONE    = 1;
    localparam int unsigned ST_TIMEOUT = 2;
    localparam int unsigned ST_ABORTED = 3;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ARM       = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/acq_seq_edge_det.sv
// Purpose : rising-edge detect of the datapath acq_done level, optional 2-flop synchronizer.
// Latency : done_rise combinational from the (synchronized) level; +2 cycles with ACQ_SEQ_DONE_SYNC_EN.
// Backpressure: none, single-cycle pulse output.
//
// Ports: clk, reset (sync, active-high), acq_done (level in), done_rise (1-cycle pulse out).
// Build option: define ACQ_SEQ_DONE_SYNC_EN when acq_done comes from another clock domain.
module acq_seq_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic acq_done,
    output logic done_rise
);

    logic done_s;
    logic done_q;

`ifdef ACQ_SEQ_DONE_SYNC_EN
    logic sync_ff1;
    logic sync_ff2;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_ff1 <= 1'b0;
            sync_ff2 <= 1'b0;
        end else begin
            sync_ff1 <= acq_done;
            sync_ff2 <= sync_ff1;
        end
    end

    assign done_s = sync_ff2;
`else
    assign done_s = acq_done;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            done_q <= 1'b0;
        end else begin
            done_q <= done_s;
        end
    end

    assign done_rise = done_s & ~done_q;

endmodule

// File: rtl/acq_seq_ctrl.sv
// Purpose : Avalon-MM sequencer issuing one acq_start pulse per frame and counting acq_done edges.
// Latency : readdata 1 cycle after address; acq_start asserted the cycle after START is written.
// Backpressure: none; writes always accepted, START ignored while a sequence is running.
//
// Ports: clk, reset (sync, active-high); Avalon slave address/write/writedata/readdata;
//        acq_done (datapath level in), acq_start (frame trigger out), busy, irq (level).
// Build option: ACQ_SEQ_DONE_SYNC_EN adds a 2-flop synchronizer on acq_done.
module acq_seq_ctrl
    import acq_seq_pkg::*;
#(
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int START_PULSE_W  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  address,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic        acq_done,
    output logic        acq_start,
    output logic        busy,
    output logic        irq
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
    localparam int PW_W  = (START_PULSE_W > 1) ? $clog2(START_PULSE_W) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [PW_W-1:0]  PW_LAST  = PW_W'(START_PULSE_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    state_t             state;
    logic               irq_en;
    logic [CNT_W-1:0]   num_frames;
    logic [CNT_W-1:0]   frames_left;
    logic [CNT_W-1:0]   frame_cnt;
    logic [TMO_W-1:0]   tmo_cnt;
    logic [PW_W-1:0]    pulse_cnt;
    logic               done_flag;
    logic               timeout_flag;
    logic               aborted_flag;
    logic               done_rise;
    logic [31:0]        rd_mux;

    logic wr_ctrl;
    logic wr_num;
    logic wr_status;
    logic start_req;
    logic abort_req;
    logic unused_wd;

    assign wr_ctrl   = write && (address == REG_CTRL);
    assign wr_num    = write && (address == REG_NUM_FRAMES);
    assign wr_status = write && (address == REG_STATUS);
    assign abort_req = wr_ctrl && writedata[CTRL_ABORT];
    // ABORT in the same write suppresses START
    assign start_req = wr_ctrl && writedata[CTRL_START] && !writedata[CTRL_ABORT];
    assign unused_wd = ^writedata;

    acq_seq_edge_det u_edge_det (
        .clk       (clk),
        .reset     (reset),
        .acq_done  (acq_done),
        .done_rise (done_rise)
    );

    assign irq = irq_en & (done_flag | timeout_flag | aborted_flag);

    always_comb begin
        rd_mux = '0;
        case (address)
            REG_CTRL:       rd_mux[CTRL_IRQ_EN] = irq_en;
            REG_NUM_FRAMES: rd_mux[CNT_W-1:0]   = num_frames;
            REG_STATUS: begin
                rd_mux[ST_BUSY]    = busy;
                rd_mux[ST_DONE]    = done_flag;
                rd_mux[ST_TIMEOUT] = timeout_flag;
                rd_mux[ST_ABORTED] = aborted_flag;
            end
            default:        rd_mux[CNT_W-1:0]   = frame_cnt;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            readdata     <= '0;
            state        <= IDLE;
            busy         <= 1'b0;
            acq_start    <= 1'b0;
            irq_en       <= 1'b0;
            num_frames   <= '0;
            frames_left  <= '0;
            frame_cnt    <= '0;
            tmo_cnt      <= '0;
            pulse_cnt    <= '0;
            done_flag    <= 1'b0;
            timeout_flag <= 1'b0;
            aborted_flag <= 1'b0;
        end else begin
            readdata <= rd_mux;

            if (wr_ctrl) begin
                irq_en <= writedata[CTRL_IRQ_EN];
            end
            if (wr_num) begin
                num_frames <= writedata[CNT_W-1:0];
            end
            // W1C first; hardware sets below come later and therefore win
            if (wr_status) begin
                done_flag    <= done_flag    & ~writedata[ST_DONE];
                timeout_flag <= timeout_flag & ~writedata[ST_TIMEOUT];
                aborted_flag <= aborted_flag & ~writedata[ST_ABORTED];
            end

            case (state)
                IDLE: begin
                    if (start_req) begin
                        if (num_frames == '0) begin
                            done_flag <= 1'b1;
                        end else begin
                            state        <= ARM;
                            busy         <= 1'b1;
                            acq_start    <= 1'b1;
                            pulse_cnt    <= '0;
                            frames_left  <= num_frames;
                            frame_cnt    <= '0;
                            done_flag    <= 1'b0;
                            timeout_flag <= 1'b0;
                            aborted_flag <= 1'b0;
                        end
                    end
                end

                ARM: begin
                    if (abort_req) begin
                        state        <= IDLE;
                        busy         <= 1'b0;
                        acq_start    <= 1'b0;
                        aborted_flag <= 1'b1;
                    end else if (pulse_cnt == PW_LAST) begin
                        state     <= WAIT_DONE;
                        acq_start <= 1'b0;
                        tmo_cnt   <= '0;
                    end else begin
                        pulse_cnt <= pulse_cnt + PW_W'(1);
                    end
                end

                WAIT_DONE: begin
                    if (abort_req) begin
                        state        <= IDLE;
                        busy         <= 1'b0;
                        aborted_flag <= 1'b1;
                    end else if (done_rise) begin
                        // a done edge on the expiry cycle still counts the frame
                        if (frame_cnt != CNT_MAX) begin
                            frame_cnt <= frame_cnt + CNT_ONE;
                        end
                        frames_left <= frames_left - CNT_ONE;
                        if (frames_left == CNT_ONE) begin
                            state     <= IDLE;
                            busy      <= 1'b0;
                            done_flag <= 1'b1;
                        end else begin
                            state     <= ARM;
                            acq_start <= 1'b1;
                            pulse_cnt <= '0;
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        state        <= IDLE;
                        busy         <= 1'b0;
                        timeout_flag <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end

                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    acq_start <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_acq_seq_ctrl.sv
module tb_acq_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        acq_done;
    logic        acq_start;
    logic        busy;
    logic        irq;

    int checks = 0;
    int errors = 0;

    // datapath model / monitor state (owned by the monitor process)
    int resp_mode = 0;     // 0 none, 1 pulse 10 cycles, 2 raise and hold
    int cyc = 0;
    int pulses = 0;
    int cur_w = 0;
    int widths[$];
    int start_q[$];
    int hold = 0;
    int start_fall_cyc = 0;
    int busy_fall_cyc = 0;
    logic start_prev = 1'b0;
    logic busy_prev = 1'b0;

    // read scoreboard
    logic [31:0] exp_q[$];
    string       name_q[$];

    typedef struct {
        logic [1:0]  addr;
        logic        do_wr;
        logic [31:0] wdata;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[11];

    acq_seq_ctrl #(
        .CNT_W          (16),
        .TIMEOUT_CYCLES (50),
        .START_PULSE_W  (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .write     (write),
        .writedata (writedata),
        .readdata  (readdata),
        .acq_done  (acq_done),
        .acq_start (acq_start),
        .busy      (busy),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address   = a;
        writedata = d;
        write     = 1'b1;
        tick();
        write     = 1'b0;
        writedata = '0;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] e, input string nm);
        address = a;
        exp_q.push_back(e);
        name_q.push_back(nm);
        tick();
        chk(name_q.pop_front(), readdata, exp_q.pop_front());
    endtask

    task automatic wait_idle(input int budget, input string nm);
        int n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        chk({nm, " idle"}, 32'(busy), 32'd0);
    endtask

    // monitor + acquisition datapath model, all on the falling edge
    initial begin
        acq_done = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (acq_start && !start_prev) begin
                pulses++;
                cur_w = 1;
                start_q.push_back(cyc);
            end else if (acq_start) begin
                cur_w++;
            end
            if (!acq_start && start_prev) begin
                widths.push_back(cur_w);
                start_fall_cyc = cyc;
            end
            if (!busy && busy_prev) busy_fall_cyc = cyc;
            start_prev = acq_start;
            busy_prev  = busy;
            case (resp_mode)
                0: begin
                    acq_done = 1'b0;
                    hold = 0;
                    start_q.delete();
                end
                1: begin
                    if (hold > 0) begin
                        hold--;
                        if (hold == 0) acq_done = 1'b0;
                    end else if (!acq_done && start_q.size() > 0 && cyc >= start_q[0] + 5) begin
                        void'(start_q.pop_front());
                        acq_done = 1'b1;
                        hold = 10;
                    end
                end
                default: begin
                    if (!acq_done && start_q.size() > 0 && cyc >= start_q[0] + 5) begin
                        void'(start_q.pop_front());
                        acq_done = 1'b1;
                    end
                end
            endcase
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int w0;
        int n;
        logic seen;

        vecs[0]  = '{2'd0, 1'b0, 32'h0,     32'h0,    "reset CTRL"};
        vecs[1]  = '{2'd1, 1'b0, 32'h0,     32'h0,    "reset NUM_FRAMES"};
        vecs[2]  = '{2'd2, 1'b0, 32'h0,     32'h0,    "reset STATUS"};
        vecs[3]  = '{2'd3, 1'b0, 32'h0,     32'h0,    "reset FRAME_CNT"};
        vecs[4]  = '{2'd1, 1'b1, 32'hFFFF,  32'hFFFF, "NUM_FRAMES rw max"};
        vecs[5]  = '{2'd1, 1'b1, 32'h12345, 32'h2345, "NUM_FRAMES truncate"};
        vecs[6]  = '{2'd0, 1'b1, 32'h4,     32'h4,    "CTRL irq_en"};
        vecs[7]  = '{2'd0, 1'b1, 32'h6,     32'h4,    "CTRL abort idle"};
        vecs[8]  = '{2'd2, 1'b1, 32'hF,     32'h0,    "STATUS w1c idle"};
        vecs[9]  = '{2'd3, 1'b1, 32'h7,     32'h0,    "FRAME_CNT ro"};
        vecs[10] = '{2'd0, 1'b1, 32'h0,     32'h0,    "CTRL clear"};

        reset = 1'b1; write = 1'b0; address = '0; writedata = '0;
        repeat (3) tick();
        reset = 1'b0;
        chk("reset acq_start", 32'(acq_start), 32'd0);
        chk("reset irq", 32'(irq), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);

        foreach (vecs[i]) begin
            if (vecs[i].do_wr) wr(vecs[i].addr, vecs[i].wdata);
            rd(vecs[i].addr, vecs[i].exp, vecs[i].name);
        end

        // three frames with a responding datapath and interrupts on
        resp_mode = 1;
        p0 = pulses; w0 = widths.size();
        wr(2'd1, 32'd3);
        wr(2'd0, 32'h5);
        wait_idle(600, "3 frames");
        repeat (2) tick();
        chk("3 frames pulse count", 32'(pulses - p0), 32'd3);
        for (int i = 0; i < 3; i++)
            chk($sformatf("3 frames pulse%0d width", i), 32'(widths[w0 + i]), 32'd4);
        rd(2'd3, 32'd3, "3 frames FRAME_CNT");
        rd(2'd2, 32'h2, "3 frames STATUS");
        rd(2'd0, 32'h4, "3 frames CTRL");
        chk("3 frames irq", 32'(irq), 32'd1);
        wr(2'd2, 32'h2);
        chk("irq after w1c", 32'(irq), 32'd0);
        rd(2'd2, 32'h0, "STATUS after w1c");
        resp_mode = 0;
        tick();

        // timeout with no acq_done; clear TIMEOUT on the very edge it is set
        p0 = pulses;
        wr(2'd1, 32'd2);
        wr(2'd0, 32'h1);
        seen = 1'b0;
        n = 0;
        while (!seen && n < 20) begin
            tick();
            n++;
            if (!acq_start) seen = 1'b1;
        end
        chk("timeout start fell", 32'(seen), 32'd1);
        repeat (49) tick();
        wr(2'd2, 32'h4);
        chk("timeout busy at expiry", 32'(busy), 32'd0);
        wait_idle(100, "timeout");
        tick();
        chk("timeout delay", 32'(busy_fall_cyc - start_fall_cyc), 32'd50);
        rd(2'd2, 32'h4, "timeout STATUS set wins w1c");
        rd(2'd3, 32'd0, "timeout FRAME_CNT");
        chk("timeout pulse count", 32'(pulses - p0), 32'd1);

        // abort after the second completed frame
        resp_mode = 1;
        p0 = pulses;
        wr(2'd1, 32'd5);
        wr(2'd0, 32'h1);
        address = 2'd3;
        seen = 1'b0;
        n = 0;
        while (!seen && n < 300) begin
            tick();
            n++;
            if (readdata == 32'd2) seen = 1'b1;
        end
        chk("abort saw 2 frames", 32'(seen), 32'd1);
        wr(2'd0, 32'h2);
        chk("abort acq_start", 32'(acq_start), 32'd0);
        chk("abort busy", 32'(busy), 32'd0);
        n = pulses;
        repeat (60) tick();
        chk("abort no more pulses", 32'(pulses - n), 32'd0);
        chk("abort pulses total", 32'(pulses - p0), 32'd3);
        rd(2'd2, 32'h8, "abort STATUS");
        rd(2'd3, 32'd2, "abort FRAME_CNT");
        resp_mode = 0;
        tick();
        p0 = pulses;
        wr(2'd0, 32'h3);
        tick();
        chk("start+abort busy", 32'(busy), 32'd0);
        chk("start+abort pulses", 32'(pulses - p0), 32'd0);
        rd(2'd2, 32'h8, "start+abort STATUS");

        // START while busy is ignored; NUM_FRAMES write accepted
        resp_mode = 1;
        p0 = pulses;
        wr(2'd1, 32'd2);
        wr(2'd0, 32'h1);
        wr(2'd1, 32'd5);
        wr(2'd0, 32'h1);
        wait_idle(400, "busy start");
        repeat (2) tick();
        chk("busy start pulses", 32'(pulses - p0), 32'd2);
        rd(2'd3, 32'd2, "busy start FRAME_CNT");
        rd(2'd1, 32'd5, "busy start NUM_FRAMES");
        rd(2'd2, 32'h2, "busy start STATUS");
        resp_mode = 0;
        tick();

        // START with zero frames
        wr(2'd2, 32'hE);
        rd(2'd2, 32'h0, "zero STATUS cleared");
        p0 = pulses;
        wr(2'd1, 32'd0);
        wr(2'd0, 32'h1);
        rd(2'd2, 32'h2, "zero STATUS done");
        chk("zero busy", 32'(busy), 32'd0);
        chk("zero pulses", 32'(pulses - p0), 32'd0);

        // acq_done held high: second frame sees no edge and times out
        resp_mode = 2;
        p0 = pulses;
        wr(2'd1, 32'd2);
        wr(2'd0, 32'h1);
        wait_idle(400, "held");
        repeat (2) tick();
        chk("held pulses", 32'(pulses - p0), 32'd2);
        rd(2'd3, 32'd1, "held FRAME_CNT");
        rd(2'd2, 32'h4, "held STATUS");
        resp_mode = 0;
        repeat (2) tick();

        // reset in the middle of a sequence
        wr(2'd1, 32'd3);
        wr(2'd0, 32'h5);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midreset acq_start", 32'(acq_start), 32'd0);
        chk("midreset busy", 32'(busy), 32'd0);
        chk("midreset irq", 32'(irq), 32'd0);
        rd(2'd2, 32'h0, "midreset STATUS");
        rd(2'd1, 32'h0, "midreset NUM_FRAMES");
        rd(2'd0, 32'h0, "midreset CTRL");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
